// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK up/down modulo counter.
// Direction encodings and the JK excitation helper.
package jk_cnt_pkg;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Excitation that moves Q to d on the next edge: {J,K}
    function automatic logic [1:0] jk_drive(input logic d, input logic q);
        return {d & ~q, ~d & q};
    endfunction

endpackage

// File: rtl/jk_updown_counter_if.sv
// Control/status bundle of the JK up/down counter.
// master drives controls, slave is the counter.
interface jk_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, wrap
    );
endinterface

// File: rtl/jk_updown_counter_jkff.sv
// JK flip-flop with asynchronous active-high reset (Q=0, NQ=1).
// JK: 00 hold, 10 set, 01 clear, 11 toggle.
module jk_ff_r (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic nq
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign nq = ~q;

endmodule

// File: rtl/jk_updown_counter.sv
// Up/down modulo-MODULUS counter built from JK flip-flops.
// `define JKCNT_SATURATE_EN for a saturating counter (wrap tied low).
module jk_updown_counter
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic                clk,
    input  logic                rst,
    jk_updown_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] d;
    logic             go_up;
    logic             go_dn;
`ifndef JKCNT_SATURATE_EN
    logic             wrap_d;
    logic             wrap_q;
`endif

    assign go_up = ~bus.load & bus.en & (bus.up == DIR_UP);
    assign go_dn = ~bus.load & bus.en & (bus.up == DIR_DOWN);

    always_comb begin
        d = q;
`ifndef JKCNT_SATURATE_EN
        wrap_d = 1'b0;
`endif
        unique case (1'b1)
            bus.load: begin
                d = (bus.load_val > MAX) ? MAX : bus.load_val;
            end
            go_up: begin
                if (q == MAX) begin
`ifdef JKCNT_SATURATE_EN
                    d = MAX;
`else
                    d      = '0;
                    wrap_d = 1'b1;
`endif
                end else begin
                    d = q + 1'b1;
                end
            end
            go_dn: begin
                if (q == '0) begin
`ifdef JKCNT_SATURATE_EN
                    d = '0;
`else
                    d      = MAX;
                    wrap_d = 1'b1;
`endif
                end else begin
                    d = q - 1'b1;
                end
            end
            default: d = q;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [1:0] jk;
        assign jk = jk_drive(d[i], q[i]);
        jk_ff_r u_ff (
            .clk (clk),
            .rst (rst),
            .j   (jk[1]),
            .k   (jk[0]),
            .q   (q[i]),
            .nq  (nq[i])
        );
    end

    // Zero detect taken from the NQ rail: all NQ high means count is 0
    assign bus.tc = bus.en & ((bus.up == DIR_UP) ? (q == MAX) : (&nq));
    assign bus.count = q;

`ifdef JKCNT_SATURATE_EN
    assign bus.wrap = 1'b0;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.wrap = wrap_q;
`endif

endmodule

// File: tb/tb_jk_updown_counter.sv
// Randomised self-checking bench for jk_updown_counter.
// Main DUT: WIDTH=4, MODULUS=10; second DUT: MODULUS=16.
module tb_jk_updown_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    int   m_cnt;
    bit   m_wrap;
    bit   exp_tc;
    logic obs_tc;

    jk_updown_counter_if #(.WIDTH(W)) a ();
    jk_updown_counter_if #(.WIDTH(W)) b ();

    jk_updown_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    jk_updown_counter #(.WIDTH(W), .MODULUS(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    always #5 clk = ~clk;

    // Reference: what one rising edge does to the count
    task automatic model_edge(input bit e, input bit u, input bit l, input int lv);
        if (l) begin
            m_cnt  = (lv >= MOD) ? MOD - 1 : lv;
            m_wrap = 0;
        end else if (e) begin
`ifdef JKCNT_SATURATE_EN
            if (u) m_cnt = (m_cnt == MOD - 1) ? m_cnt : m_cnt + 1;
            else   m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
            m_wrap = 0;
`else
            m_wrap = u ? (m_cnt == MOD - 1) : (m_cnt == 0);
            m_cnt  = u ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
`endif
        end else begin
            m_wrap = 0;
        end
    endtask

    // Apply inputs, sample tc mid-cycle, take one edge, settle
    task automatic step(input bit e, input bit u, input bit l, input int lv);
        a.en = e; a.up = u; a.load = l; a.load_val = W'(lv);
        #1;
        exp_tc = e && (u ? (m_cnt == MOD - 1) : (m_cnt == 0));
        obs_tc = a.tc;
        @(posedge clk);
        model_edge(e, u, l, lv);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a.en = 0; a.up = 1; a.load = 0; a.load_val = '0;
        b.en = 0; b.up = 1; b.load = 0; b.load_val = '0;
        m_cnt = 0; m_wrap = 0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (a.count !== 4'd0 || a.wrap !== 1'b0 || a.tc !== 1'b0) begin
            n_err++;
            $display("FAIL reset: count=%0d wrap=%b tc=%b want 0 0 0", a.count, a.wrap, a.tc);
        end
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_up_run;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0);
            n_chk++;
            if (a.count !== W'(m_cnt) || a.wrap !== m_wrap || obs_tc !== exp_tc) begin
                n_err++;
                $display("FAIL up_run[%0d]: count=%0d wrap=%b tc=%b want %0d %b %b",
                         i, a.count, a.wrap, obs_tc, m_cnt, m_wrap, exp_tc);
            end
        end
    endtask

    task automatic test_down_wrap;
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            n_chk++;
            if (a.count !== W'(m_cnt) || a.wrap !== m_wrap || obs_tc !== exp_tc) begin
                n_err++;
                $display("FAIL down_wrap[%0d]: count=%0d wrap=%b tc=%b want %0d %b %b",
                         i, a.count, a.wrap, obs_tc, m_cnt, m_wrap, exp_tc);
            end
        end
    endtask

    task automatic test_load;
        step(1, 1, 1, 6);
        n_chk++;
        if (a.count !== 4'd6 || a.wrap !== 1'b0) begin
            n_err++;
            $display("FAIL load6: count=%0d wrap=%b want 6 0", a.count, a.wrap);
        end
        step(1, 0, 1, 12);
        n_chk++;
        if (a.count !== 4'd9 || a.wrap !== 1'b0) begin
            n_err++;
            $display("FAIL load_clamp: count=%0d wrap=%b want 9 0", a.count, a.wrap);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            n_chk++;
            if (a.count !== 4'd9 || a.wrap !== 1'b0 || obs_tc !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: count=%0d wrap=%b tc=%b want 9 0 0",
                         i, a.count, a.wrap, obs_tc);
            end
        end
    endtask

    task automatic test_async_reset;
        step(0, 1, 1, 7);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        n_chk++;
        if (a.count !== W'(m_cnt) || a.wrap !== m_wrap) begin
            n_err++;
            $display("FAIL pre_rst: count=%0d wrap=%b want %0d %b", a.count, a.wrap, m_cnt, m_wrap);
        end
        a.en = 0;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (a.count !== 4'd0 || a.wrap !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: count=%0d wrap=%b want 0 0", a.count, a.wrap);
        end
        a.en = 1; a.up = 1;
        @(posedge clk);
        #1;
        n_chk++;
        if (a.count !== 4'd0 || a.wrap !== 1'b0) begin
            n_err++;
            $display("FAIL rst_hold: count=%0d wrap=%b want 0 0", a.count, a.wrap);
        end
        #2 rst = 1'b0;
        m_cnt = 0; m_wrap = 0;
        step(1, 1, 0, 0);
        n_chk++;
        if (a.count !== 4'd1 || a.wrap !== 1'b0) begin
            n_err++;
            $display("FAIL rst_release: count=%0d wrap=%b want 1 0", a.count, a.wrap);
        end
    endtask

    task automatic test_dir_flip;
        step(0, 0, 1, 5);
        for (int i = 0; i < 4; i++) begin
            step(1, (i % 2 == 0), 0, 0);
            n_chk++;
            if (a.count !== W'(m_cnt) || a.count !== W'((i % 2 == 0) ? 6 : 5)) begin
                n_err++;
                $display("FAIL dir_flip[%0d]: count=%0d want %0d", i, a.count, m_cnt);
            end
        end
    endtask

    task automatic test_mod16;
        a.en = 0; a.load = 0;
        b.load = 1; b.load_val = 4'd15; b.en = 0;
        @(posedge clk);
        model_edge(0, 0, 0, 0);
        #1;
        b.load = 0; b.en = 1; b.up = 1;
        #1;
        n_chk++;
        if (b.count !== 4'd15 || b.tc !== 1'b1) begin
            n_err++;
            $display("FAIL mod16_tc: count=%0d tc=%b want 15 1", b.count, b.tc);
        end
        @(posedge clk);
        model_edge(0, 0, 0, 0);
        #1;
        b.en = 0;
        n_chk++;
`ifdef JKCNT_SATURATE_EN
        if (b.count !== 4'd15 || b.wrap !== 1'b0) begin
            n_err++;
            $display("FAIL mod16_sat: count=%0d wrap=%b want 15 0", b.count, b.wrap);
        end
`else
        if (b.count !== 4'd0 || b.wrap !== 1'b1) begin
            n_err++;
            $display("FAIL mod16_wrap: count=%0d wrap=%b want 0 1", b.count, b.wrap);
        end
`endif
    endtask

    task automatic test_random;
        bit e, u, l;
        int lv;
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1) != 0;
            l  = ($urandom_range(0, 7) == 0);
            lv = $urandom_range(0, 15);
            step(e, u, l, lv);
            n_chk++;
            if (a.count !== W'(m_cnt) || a.wrap !== m_wrap || obs_tc !== exp_tc) begin
                n_err++;
                $display("FAIL random[%0d]: count=%0d wrap=%b tc=%b want %0d %b %b",
                         i, a.count, a.wrap, obs_tc, m_cnt, m_wrap, exp_tc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_down_wrap();
        test_load();
        test_async_reset();
        test_dir_flip();
        test_mod16();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
